// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the control decoder:
// fetch FSM states, the HALT encoding and the instruction type field.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int         ISA_INSTR_W = 9;
  localparam logic [8:0] HALT_INSTR  = 9'h1FF;

  // Type field occupies the two top bits of every instruction word
  localparam int TYPE_MSB = 8;
  localparam int TYPE_LSB = 7;

  typedef enum logic [1:0] {
    TYPE_ALU  = 2'b00,
    TYPE_IMM  = 2'b01,
    TYPE_MEM  = 2'b10,
    TYPE_CTRL = 2'b11
  } instr_type_t;

  function automatic instr_type_t instr_type(input logic [ISA_INSTR_W-1:0] word);
    return instr_type_t'(word[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus: instruction-memory req/ack side plus decoder valid/ready side
// with the branch redirect that travels back from execute.
interface instr_fetch_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-PC select applied on the consume cycle: branch target or pc+1,
// where the increment wraps modulo 2^PC_W without any flag.
module pc_next #(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] pc_next_o
);

  logic [PC_W-1:0] pc_inc;

  assign pc_inc    = pc_i + PC_W'(1);
  assign pc_next_o = branch_taken_i ? branch_target_i : pc_inc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory and holds it for the decoder until consumed.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter int              INSTR_W    = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  instr_fetch_if.master    bus,
  output logic [PC_W-1:0]  pc,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_nxt;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc_i            (pc_q),
    .branch_taken_i  (bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .pc_next_o       (pc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_d      = START_ADDR;
          retired_d = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = (bus.imem_rdata == HALT_INSTR) ? HALTED : HOLD;
        end
      end
      HOLD: begin
        // branch inputs only matter here, on the consume cycle
        if (bus.instr_ready) begin
          pc_d      = pc_nxt;
          retired_d = sat_inc(retired_q);
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Handshake outputs decode from state only, so reset drops them at once
  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign pc              = pc_q;
  assign halt            = (state_q == HALTED);
  assign retired         = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run, all
// compared each cycle against a flag-level behavioural model of the fetch unit.
module tb_instr_fetch;

  localparam int              PC_W    = 10;
  localparam int              INSTR_W = 9;
  localparam int              CNT_W   = 4;
  localparam logic [PC_W-1:0] START   = '0;
  localparam int              RET_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [PC_W-1:0]  pc;
  logic             halt;
  logic [CNT_W-1:0] retired;

  instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .START_ADDR(START), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
    .pc(pc), .halt(halt), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [INSTR_W-1:0] mem [0:1023];

  // Behavioural model: what the unit is doing, as plain flags and counters
  bit                 m_run, m_have, m_halt;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  int                 m_ret;

  int  n_chk = 0, n_pass = 0;
  bit  chk_en = 1'b0;
  bit  rnd = 1'b0;
  int  ack_dly = 0, rdy_dly = 0, req_cnt = 0, hold_cnt = 0, bt_mode = 0;
  bit  inject_start = 1'b0;
  logic [PC_W-1:0]    ack_addrs [$];
  logic [INSTR_W-1:0] consumed [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_have = 0; m_halt = 0;
    m_pc = START; m_instr = '0; m_ret = 0;
  endtask

  task automatic model_step();
    if (m_run) begin
      if (bus.imem_ack) begin
        m_instr = bus.imem_rdata;
        m_run   = 0;
        if (bus.imem_rdata == 9'h1FF) m_halt = 1; else m_have = 1;
      end
    end else if (m_have) begin
      if (bus.instr_ready) begin
        m_pc   = bus.branch_taken ? bus.branch_target
                                  : PC_W'((32'(m_pc) + 1) % (1 << PC_W));
        m_ret  = (m_ret == RET_MAX) ? m_ret : m_ret + 1;
        m_have = 0;
        m_run  = 1;
      end
    end else if (start) begin
      m_halt = 0; m_pc = START; m_ret = 0; m_run = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", 32'(bus.imem_req), 32'(m_run));
      if (m_run) chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("instr_valid", 32'(bus.instr_valid), 32'(m_have));
      chk("instr", 32'(bus.instr), 32'(m_instr));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("halt", 32'(halt), 32'(m_halt));
      chk("retired", 32'(retired), 32'(m_ret));
    end
  end

  task automatic tick();
    if (bus.instr_valid && bus.instr_ready) consumed.push_back(bus.instr);
    if (bus.imem_req && bus.imem_ack) ack_addrs.push_back(bus.imem_addr);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic drive();
    bus.imem_rdata = mem[bus.imem_addr];
    if (rnd) begin
      bus.imem_ack      = 1'($urandom_range(0, 1));
      bus.instr_ready   = ($urandom_range(0, 9) < 6);
      bus.branch_taken  = ($urandom_range(0, 9) < 3);
      bus.branch_target = PC_W'($urandom);
      start             = ($urandom_range(0, 19) == 0);
    end else begin
      req_cnt  = bus.imem_req ? req_cnt + 1 : 0;
      hold_cnt = bus.instr_valid ? hold_cnt + 1 : 0;
      bus.imem_ack    = bus.imem_req && (req_cnt > ack_dly);
      bus.instr_ready = bus.instr_valid && (hold_cnt > rdy_dly);
      start           = inject_start && bus.instr_valid && (hold_cnt == 2);
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      case (bt_mode)
        1: begin
          bus.branch_taken  = 1'b1;
          bus.branch_target = !bus.instr_valid ? 10'h200 : 10'h040;
          if (bus.instr_valid && pc != 10'h001) bus.branch_taken = 1'b0;
        end
        2: begin
          bus.branch_taken  = bus.instr_valid && (pc == 10'h000) && (consumed.size() == 0);
          bus.branch_target = 10'h3FF;
        end
        default: ;
      endcase
    end
  endtask

  task automatic begin_run();
    consumed.delete();
    ack_addrs.delete();
    drive();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_halt(input int max_cycles, input string name);
    for (int k = 0; k < max_cycles; k++) begin
      drive();
      tick();
      if (halt) break;
    end
    chk(name, 32'(halt), 32'd1);
  endtask

  initial begin
    bus.imem_ack = 0; bus.imem_rdata = '0; bus.instr_ready = 0;
    bus.branch_taken = 0; bus.branch_target = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #2 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Sequential fetch to HALT
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h1FF;
    begin_run();
    run_until_halt(30, "seq_halt_reached");
    chk("seq_n_consumed", 32'(consumed.size()), 32'd2);
    chk("seq_instr0", 32'(consumed[0]), 32'h001);
    chk("seq_instr1", 32'(consumed[1]), 32'h002);
    chk("seq_pc", 32'(pc), 32'd2);
    chk("seq_retired", 32'(retired), 32'd2);
    chk("seq_model_ret", 32'(m_ret), 32'd2);
    repeat (3) begin drive(); tick(); end
    chk("seq_req_after_halt", 32'(bus.imem_req), 32'd0);

    // Restart from HALTED, branch on consume of address 1, REQ-time branch ignored
    mem[0] = 9'h003; mem[1] = 9'h004; mem[10'h040] = 9'h1FF;
    bt_mode = 1;
    begin_run();
    chk("restart_halt", 32'(halt), 32'd0);
    chk("restart_retired", 32'(retired), 32'd0);
    chk("restart_req", 32'(bus.imem_req), 32'd1);
    chk("restart_addr", 32'(bus.imem_addr), 32'(START));
    run_until_halt(30, "br_halt_reached");
    chk("br_n_fetch", 32'(ack_addrs.size()), 32'd3);
    chk("br_fetch1", 32'(ack_addrs[1]), 32'h001);
    chk("br_fetch2", 32'(ack_addrs[2]), 32'h040);
    chk("br_pc", 32'(pc), 32'h040);
    bt_mode = 0;

    // Wait states and backpressure, with a start pulse during HOLD
    mem[0] = 9'h005; mem[1] = 9'h1FF;
    ack_dly = 3; rdy_dly = 4; inject_start = 1'b1;
    begin_run();
    run_until_halt(60, "bp_halt_reached");
    chk("bp_n_consumed", 32'(consumed.size()), 32'd1);
    chk("bp_instr0", 32'(consumed[0]), 32'h005);
    chk("bp_retired", 32'(retired), 32'd1);
    chk("bp_pc", 32'(pc), 32'd1);
    ack_dly = 0; rdy_dly = 0; inject_start = 1'b0;

    // Retired counter saturation
    for (int i = 0; i < 20; i++) mem[i] = 9'(i + 1);
    mem[20] = 9'h1FF;
    begin_run();
    run_until_halt(100, "sat_halt_reached");
    chk("sat_retired", 32'(retired), 32'(RET_MAX));
    chk("sat_pc", 32'(pc), 32'd20);

    // PC wrap 3FF -> 000, then reset while requesting
    mem[0] = 9'h006; mem[10'h3FF] = 9'h007;
    bt_mode = 2;
    begin_run();
    for (int k = 0; k < 40; k++) begin
      drive();
      tick();
      if (consumed.size() >= 2) break;
    end
    bt_mode = 0;
    bus.imem_ack = 1'b0;
    chk("wrap_fetch1", 32'(ack_addrs[1]), 32'h3FF);
    chk("wrap_req", 32'(bus.imem_req), 32'd1);
    chk("wrap_addr", 32'(bus.imem_addr), 32'h000);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_req", 32'(bus.imem_req), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = 9'h006;
      tick();
    end
    chk("late_ack_req", 32'(bus.imem_req), 32'd0);
    chk("late_ack_valid", 32'(bus.instr_valid), 32'd0);
    chk("late_ack_instr", 32'(bus.instr), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 39) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
    rnd = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      drive();
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 9-bit processor. It owns the program counter, requests 9-bit instruction words from instruction memory over a req/ack handshake, and presents each word to the control decoder over a valid/ready handshake. It applies branch redirects when the decode/execute side consumes an instruction, and stops on the HALT encoding. It sits between instruction memory and the control decoder / register-file front end.

## Interface
Parameters:
- PC_W, 10, program counter and instruction memory address width
- INSTR_W, 9, instruction width; fixed at 9 for this ISA
- START_ADDR, 0, PC value loaded at reset and on every start
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins execution at START_ADDR; honoured only in IDLE or HALTED
- imem_req  out  1  instruction memory read request
- imem_addr  out  PC_W  read address; equals pc while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  INSTR_W  instruction word; valid only when imem_ack=1
- instr  out  INSTR_W  registered instruction to the decoder
- instr_valid  out  1  instr holds an unconsumed instruction
- instr_ready  in  1  decoder/execute accepts instr this cycle
- branch_taken  in  1  redirect; sampled only on the consume cycle (instr_valid & instr_ready)
- branch_target  in  PC_W  next PC when branch_taken is sampled high
- pc  out  PC_W  address of the current or pending instruction
- halt  out  1  HALT fetched; fetch stopped
- retired  out  CNT_W  count of consumed instructions, saturating

## Operation
- FSM states: IDLE, REQ, HOLD, HALTED.
- IDLE: all handshake outputs low. On start: pc←START_ADDR, retired←0, go to REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: instr←imem_rdata. If imem_rdata==HALT_INSTR (9'h1FF), go to HALTED with halt=1 and instr_valid=0. Otherwise go to HOLD.
- HOLD: instr_valid=1, instr held stable. On instr_ready: pc←branch_taken ? branch_target : pc+1, retired←retired+1 (saturating at all-ones), go to REQ.
- HALTED: halt=1, pc frozen at the HALT address. On start: clear halt, pc←START_ADDR, retired←0, go to REQ.
- pc+1 wraps modulo 2^PC_W; 2^PC_W−1 → 0 is legal and produces no flag.
- branch_taken/branch_target are ignored outside the consume cycle.
- start is ignored in REQ and HOLD.

## Timing
- Reset (asynchronous, active-low): state=IDLE, pc=START_ADDR, instr=0, instr_valid=0, imem_req=0, halt=0, retired=0. imem_req drops immediately on rst_n assertion, even mid-request. A late imem_ack after reset is ignored.
- start in cycle 0 → imem_req=1 in cycle 1.
- imem_ack is sampled at the rising edge, so instr_valid rises the cycle after the ack cycle.
- Consume at edge N → imem_req=1 in cycle N+1 with the new pc.
- Best-case throughput with zero-wait memory and instr_ready tied high: one instruction per 2 cycles.
- Wait states: imem_req and imem_addr stay stable until ack. instr and instr_valid stay stable until ready.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, HOLD, HALTED}
  - HALT_INSTR = 9'h1FF
  - instruction-field constants for Type [8:7], shared with the control decoder
- One natural sub-module, pc_next: combinational next-PC select (increment with wrap, or branch target). Everything else is in instr_fetch.

## Test plan
- Sequential fetch: memory holds 9'h001, 9'h002, 9'h1FF at addresses 0..2; zero-wait ack; ready=1; pulse start → decoder sees 9'h001 then 9'h002; halt=1 with pc=2; retired=2; imem_req stays 0 afterwards.
- Branch: on the consume cycle of the instruction at address 1, drive branch_taken=1, branch_target=10'h040 → next imem_addr=10'h040. A branch_taken pulse during REQ has no effect.
- Backpressure and wait states: ack delayed 3 cycles, ready held low 4 cycles → imem_addr is constant during the wait, instr is constant while valid=1, and exactly one consume is counted.
- Wrap: branch to 10'h3FF holding a non-HALT word, then consume → next imem_addr=10'h000.
- Reset mid-request: assert rst_n=0 while imem_req=1 → imem_req=0 with no clock edge needed; after release, state=IDLE, pc=0, and ack pulses are ignored until start.
- Restart from HALTED: pulse start → halt=0, retired=0, and fetch resumes at START_ADDR. A start pulse while in HOLD is ignored (pc unchanged).
